// File: rtl/pixel_readout_capture_if.sv
// Downstream pixel stream of the readout capture block.
// Valid/ready: a word transfers on any clock edge where Out_Valid and Out_Ready are both high;
// once Out_Valid is raised, Out_Data/Out_Last hold and Out_Valid stays high until that transfer.
interface pixel_readout_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] Out_Data;
    logic              Out_Valid;
    logic              Out_Ready;
    logic              Out_Last;

    modport master (
        output Out_Data,
        output Out_Valid,
        output Out_Last,
        input  Out_Ready
    );

    modport slave (
        input  Out_Data,
        input  Out_Valid,
        input  Out_Last,
        output Out_Ready
    );
endinterface

// File: rtl/pixel_readout_capture.sv
// Captures both column ADC words per row strobe of the 2x2 array, buffers the four-pixel frame
// and streams it out; flags readout sequences that break the row1 -> row2 -> drain order.
module pixel_readout_capture #(
    parameter int DATA_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     NRE_1,
    input  logic                     NRE_2,
    input  logic                     ADC,
    input  logic                     Expose,
    input  logic                     Erase,
    input  logic [DATA_W-1:0]        Col0_Data,
    input  logic [DATA_W-1:0]        Col1_Data,
    pixel_readout_capture_if.master  out_if,
    output logic                     Frame_Done,
    output logic                     Seq_Err,
    output logic                     Busy,
    output logic [1:0]               dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROW1   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t            state_q;
    logic              adc_q;
    logic              expose_q;
    logic [DATA_W-1:0] p_q [4];
    logic [1:0]        idx_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              frame_done_q;
    logic              seq_err_q;
    logic              busy_q;

    logic adc_rise;
    logic exp_rise;
    logic err_set;
    logic seq_err_d;

    assign adc_rise = ADC & ~adc_q;
    assign exp_rise = Expose & ~expose_q;

    // Any strobe that does not fit the row1 -> row2 order, or arrives while draining, is an error.
    always_comb begin
        err_set = 1'b0;
        if (adc_rise) begin
            case (state_q)
                S_IDLE:   err_set = ~(NRE_1 & ~NRE_2 & ~Erase);
                S_ROW1:   err_set = ~(NRE_2 & ~NRE_1);
                S_STREAM: err_set = 1'b1;
                default:  err_set = 1'b0;
            endcase
        end
    end

    // A new error in the same cycle as the Expose edge keeps the flag set.
    assign seq_err_d = err_set | (seq_err_q & ~exp_rise);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            adc_q        <= 1'b0;
            expose_q     <= 1'b0;
            for (int i = 0; i < 4; i++) p_q[i] <= '0;
            idx_q        <= 2'd0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            seq_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            adc_q        <= ADC;
            expose_q     <= Expose;
            seq_err_q    <= seq_err_d;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (adc_rise && NRE_1 && !NRE_2 && !Erase) begin
                        p_q[0]  <= Col0_Data;
                        p_q[1]  <= Col1_Data;
                        state_q <= S_ROW1;
                        busy_q  <= 1'b1;
                    end
                end
                S_ROW1: begin
                    if (adc_rise) begin
                        if (NRE_2 && !NRE_1) begin
                            p_q[2]      <= Col0_Data;
                            p_q[3]      <= Col1_Data;
                            idx_q       <= 2'd0;
                            out_data_q  <= p_q[0];
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                            state_q     <= S_STREAM;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else if (Erase) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_STREAM: begin
                    // Erase and overrun strobes never disturb a frame that is draining.
                    if (out_valid_q && out_if.Out_Ready) begin
                        idx_q <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            out_data_q   <= '0;
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= S_IDLE;
                        end else begin
                            out_data_q <= p_q[idx_q + 2'd1];
                            out_last_q <= (idx_q == 2'd2);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_if.Out_Data  = out_data_q;
    assign out_if.Out_Valid = out_valid_q;
    assign out_if.Out_Last  = out_last_q;
    assign Frame_Done       = frame_done_q;
    assign Seq_Err          = seq_err_q;
    assign Busy             = busy_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pixel_readout_capture.sv
// Bench for pixel_readout_capture: fixed vector table, corner-case sequences and a random run,
// all checked cycle by cycle against a frame-queue model of the readout protocol.
module tb_pixel_readout_capture;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       NRE_1, NRE_2, ADC, Expose, Erase;
    logic [7:0] Col0_Data, Col1_Data;
    logic       Frame_Done, Seq_Err, Busy;
    logic [1:0] dbg_state;

    pixel_readout_capture_if #(.DATA_W(8)) out_if ();

    pixel_readout_capture #(.DATA_W(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .NRE_1      (NRE_1),
        .NRE_2      (NRE_2),
        .ADC        (ADC),
        .Expose     (Expose),
        .Erase      (Erase),
        .Col0_Data  (Col0_Data),
        .Col1_Data  (Col1_Data),
        .out_if     (out_if.master),
        .Frame_Done (Frame_Done),
        .Seq_Err    (Seq_Err),
        .Busy       (Busy),
        .dbg_state_o(dbg_state)
    );

    always #5 Clk = ~Clk;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;

    // Model: words still owed downstream, the pending row-1 pair, and the flag/pulse outputs.
    logic [7:0] exp_q[$];
    bit         m_pend;
    logic [7:0] m_p0, m_p1;
    bit         m_err, m_done, m_adc_prev, m_exp_prev;

    typedef struct {
        logic       nre1, nre2, adc, expose, erase, ready;
        logic [7:0] c0, c1;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last, e_done, e_err, e_busy;
    } vec_t;
    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pend = 0; m_err = 0; m_done = 0; m_adc_prev = 0; m_exp_prev = 0;
    endtask

    // Effect of the coming clock edge on the model, from the inputs currently driven.
    task automatic model_step();
        bit adc_rise, exp_rise, draining, hs, err;
        adc_rise = ADC && !m_adc_prev;
        exp_rise = Expose && !m_exp_prev;
        draining = exp_q.size() > 0;
        hs       = draining && out_if.Out_Ready;
        err      = 0;
        m_done   = hs && exp_q.size() == 1;
        if (hs) void'(exp_q.pop_front());
        if (adc_rise) begin
            if (draining) err = 1;
            else if (m_pend) begin
                if (NRE_2 && !NRE_1) begin
                    exp_q.push_back(m_p0); exp_q.push_back(m_p1);
                    exp_q.push_back(Col0_Data); exp_q.push_back(Col1_Data);
                end else err = 1;
                m_pend = 0;
            end else if (NRE_1 && !NRE_2 && !Erase) begin
                m_pend = 1; m_p0 = Col0_Data; m_p1 = Col1_Data;
            end else err = 1;
        end else if (m_pend && Erase) m_pend = 0;
        if (err) m_err = 1;
        else if (exp_rise) m_err = 0;
        m_adc_prev = ADC;
        m_exp_prev = Expose;
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        if (Frame_Done) done_cnt++;
        chk("valid", out_if.Out_Valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            chk("data", out_if.Out_Data, exp_q[0]);
            chk("last", out_if.Out_Last, exp_q.size() == 1);
        end else chk("last_idle", out_if.Out_Last, 0);
        chk("frame_done", Frame_Done, m_done);
        chk("seq_err", Seq_Err, m_err);
        chk("busy", Busy, m_pend || exp_q.size() > 0);
    endtask

    task automatic drive(input logic n1, input logic n2, input logic adc, input logic exps,
                         input logic ers, input logic [7:0] c0, input logic [7:0] c1,
                         input logic rdy);
        NRE_1 = n1; NRE_2 = n2; ADC = adc; Expose = exps; Erase = ers;
        Col0_Data = c0; Col1_Data = c1; out_if.Out_Ready = rdy;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"}, out_if.Out_Data, 0);
        chk({tag, "_valid"}, out_if.Out_Valid, 0);
        chk({tag, "_last"}, out_if.Out_Last, 0);
        chk({tag, "_done"}, Frame_Done, 0);
        chk({tag, "_err"}, Seq_Err, 0);
        chk({tag, "_busy"}, Busy, 0);
    endtask

    // Row-1 and row-2 strobes, then drain with Out_Ready high.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        drive(1, 0, 1, 0, 0, a, b, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 1, 1, 0, 0, c, d, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) tick();
    endtask

    initial begin
        int dc;
        logic [3:0] rdy_pat;
        logic [6:0] bp;

        Reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge Clk);
        #1;
        chk_all_zero("reset");
        Reset = 1'b0;

        // Nominal frame then an out-of-order strobe cleared by Expose.
        //          n1 n2 adc exp ers rdy c0     c1     valid data   last done err busy
        vt[0]  = '{0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0};
        vt[1]  = '{1, 0, 1, 0, 0, 0, 8'h11, 8'h22, 0, 8'h00, 0, 0, 0, 1};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 1};
        vt[3]  = '{0, 1, 1, 0, 0, 1, 8'h33, 8'h44, 1, 8'h11, 0, 0, 0, 1};
        vt[4]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h22, 0, 0, 0, 1};
        vt[5]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h33, 0, 0, 0, 1};
        vt[6]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 1, 8'h44, 1, 0, 0, 1};
        vt[7]  = '{0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 1, 0, 0};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0};
        vt[9]  = '{0, 1, 1, 0, 0, 0, 8'h55, 8'h66, 0, 8'h00, 0, 0, 1, 0};
        vt[10] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0};
        vt[11] = '{0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0};
        vt[12] = '{0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].nre1, vt[i].nre2, vt[i].adc, vt[i].expose, vt[i].erase,
                  vt[i].c0, vt[i].c1, vt[i].ready);
            tick();
            chk("vec_valid", out_if.Out_Valid, vt[i].e_valid);
            if (vt[i].e_valid) chk("vec_data", out_if.Out_Data, vt[i].e_data);
            chk("vec_last", out_if.Out_Last, vt[i].e_last);
            chk("vec_done", Frame_Done, vt[i].e_done);
            chk("vec_err", Seq_Err, vt[i].e_err);
            chk("vec_busy", Busy, vt[i].e_busy);
        end

        // Backpressure: Out_Ready 0,0,1,0,1,1,1 while the frame drains.
        dc = done_cnt;
        bp = 7'b1110100;
        drive(1, 0, 1, 0, 0, 8'h11, 8'h22, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 8'h33, 8'h44, 0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, bp[i]);
            tick();
        end
        chk("bp_done_seen", Frame_Done, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("bp_done_count", done_cnt - dc, 1);

        // Long strobe gives one capture; a strobe while stalled is an overrun.
        dc = done_cnt;
        repeat (3) begin drive(1, 0, 1, 0, 0, 8'h11, 8'h22, 0); tick(); end
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 8'h33, 8'h44, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 8'hAA, 8'hBB, 0); tick();
        chk("overrun_err", Seq_Err, 1);
        chk("overrun_hold", out_if.Out_Data, 8'h11);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (5) tick();
        chk("overrun_done_count", done_cnt - dc, 1);

        // Erase after row 1 abandons the frame without touching Seq_Err.
        drive(0, 0, 0, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 0, 0, 8'h55, 8'h66, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1, 0, 0, 1); tick();
        chk("abort_busy", Busy, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        chk("abort_err", Seq_Err, 0);
        chk("abort_valid", out_if.Out_Valid, 0);

        // Reset after two words accepted, then a clean frame.
        drive(1, 0, 1, 0, 0, 8'h11, 8'h22, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0, 8'h33, 8'h44, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();
        chk("pre_reset_data", out_if.Out_Data, 8'h33);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        Reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        model_reset();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        dc = done_cnt;
        run_frame(8'h01, 8'h02, 8'h03, 8'h04);
        chk("post_reset_done_count", done_cnt - dc, 1);

        // Random protocol traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            rdy_pat = 4'($urandom_range(0, 3));
            drive(r < 4 || r == 8, (r >= 4 && r < 8) || r == 8, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), rdy_pat != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
